// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the data memory.
// slave = the arbiter's view, master = the requester/memory side.
interface mem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          flush;

    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [15:0]   conflicts;

    modport slave (
        input  flush,
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output conflicts
    );

    modport master (
        output flush,
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  conflicts
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: pipeline port A has priority, debug port B
// is promoted after MAX_WAIT denied cycles. Read data returns one cycle later.

// Per-port read return: one-stage read tag plus held read data.
module mem_arbiter_rport #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic          kill,
    input  logic [DW-1:0] mem_rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);
    logic          tag;
    logic [DW-1:0] hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag  <= 1'b0;
            hold <= '0;
        end else begin
            tag  <= issue;
            hold <= rdata;
        end
    end

    // A response landing in a reset or kill cycle is dropped, not delayed.
    always_comb begin
        rvalid = tag && !kill && !rst;
        rdata  = hold;
        if (rst)
            rdata = '0;
        else if (rvalid)
            rdata = mem_rdata;
    end
endmodule

module mem_arbiter #(
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int NP = 2;
    localparam int PA = 0;
    localparam int PB = 1;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    cmd_t [NP-1:0]          cmd;
    cmd_t                   mem_cmd;
    logic [NP-1:0]          req;
    logic [NP-1:0]          gnt;
    logic [NP-1:0]          cancel;
    logic [NP-1:0]          issue_rd;
    logic [NP-1:0]          rvalid;
    logic [NP-1:0][DW-1:0]  rdata;

    logic [3:0]             b_wait;
    logic                   b_force;
    logic [15:0]            conflicts_q;

    assign req       = {bus.b_req, bus.a_req};
    assign cmd[PA]   = {bus.a_we, bus.a_addr, bus.a_wdata};
    assign cmd[PB]   = {bus.b_we, bus.b_addr, bus.b_wdata};
    // flush only ever cancels pipeline reads; debug traffic is untouched.
    assign cancel    = {1'b0, bus.flush};

    always_comb begin
        b_force = req[PB] && (b_wait == WAIT_MAX);
        gnt     = '0;
        if (!rst) begin
            gnt[PA] = req[PA] && !b_force;
            gnt[PB] = req[PB] && (b_force || !req[PA]);
        end
    end

    always_comb begin
        mem_cmd = '0;
        if (gnt[PA])
            mem_cmd = cmd[PA];
        else if (gnt[PB])
            mem_cmd = cmd[PB];
    end

    assign bus.a_gnt     = gnt[PA];
    assign bus.b_gnt     = gnt[PB];
    assign bus.mem_en    = |gnt;
    assign bus.mem_we    = mem_cmd.we;
    assign bus.mem_addr  = mem_cmd.addr;
    assign bus.mem_wdata = mem_cmd.wdata;

    // Starvation counter for B; a withdrawn B request forfeits its waiting time.
    always_ff @(posedge clk) begin
        if (rst)
            b_wait <= 4'd0;
        else if (!req[PB] || gnt[PB])
            b_wait <= 4'd0;
        else if (b_wait != WAIT_MAX)
            b_wait <= b_wait + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            conflicts_q <= 16'd0;
        else if (req[PA] && req[PB] && (conflicts_q != 16'hFFFF))
            conflicts_q <= conflicts_q + 16'd1;
    end

    assign bus.conflicts = rst ? 16'd0 : conflicts_q;

    for (genvar p = 0; p < NP; p++) begin : g_port
        assign issue_rd[p] = gnt[p] && !cmd[p].we && !cancel[p];

        mem_arbiter_rport #(.DW(DW)) u_rport (
            .clk       (clk),
            .rst       (rst),
            .issue     (issue_rd[p]),
            .kill      (cancel[p]),
            .mem_rdata (bus.mem_rdata),
            .rvalid    (rvalid[p]),
            .rdata     (rdata[p])
        );
    end

    assign bus.a_rvalid = rvalid[PA];
    assign bus.a_rdata  = rdata[PA];
    assign bus.b_rvalid = rvalid[PB];
    assign bus.b_rdata  = rdata[PB];

    a_gnt_onehot: assert property (@(posedge clk) !(gnt[PA] && gnt[PB]));
    a_wait_bound: assert property (@(posedge clk) disable iff (rst) b_wait <= WAIT_MAX);
    a_no_cmd_rst: assert property (@(posedge clk) rst |-> !bus.mem_en && !bus.mem_we);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected commands, responses
// and probes tagged with their cycle; a negedge monitor pops and compares.
module tb_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle data memory, contents mem[i] = i*10 at start.
    logic [DW-1:0] mem [64];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'(i * 10);
            bus.mem_rdata <= '0;
            mem_init <= 1'b1;
        end else if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    typedef struct { int cyc; bit port; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cmd_t;
    typedef struct { int cyc; bit port; logic [DW-1:0] data; } rsp_t;
    typedef struct { int cyc; int kind; logic [15:0] val; } prb_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    prb_t prb_q[$];

    localparam int K_CTL = 0, K_CONF = 1, K_ARD = 2, K_BRD = 3;

    function automatic void exp_cmd(bit port, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        cmd_q.push_back('{cyc, port, we, a, d});
    endfunction
    function automatic void exp_rsp(bit port, logic [DW-1:0] d);
        rsp_q.push_back('{cyc + 1, port, d});
    endfunction
    function automatic void probe(int kind, logic [15:0] v);
        prb_q.push_back('{cyc, kind, v});
    endfunction

    task automatic drive(input logic r, input logic f,
                         input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        rst = r; bus.flush = f;
        bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
        bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    endtask
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 1'b0, 1'b0, 6'd0, 16'd0);
    endtask

    // Both ports request every cycle starting with b_wait=0: grants go A,A,A,B.
    // A writes land in 40..55, B always reads addr 20 (=200).
    task automatic contend(input int n);
        int na = 0;
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 6'(40 + na % 16), 16'(na + 16'h1000),
                  1'b1, 1'b0, 6'd20, 16'd0);
            if (k % 4 == 3) begin
                exp_cmd(1'b1, 1'b0, 6'd20, 16'd0);
                exp_rsp(1'b1, 16'd200);
            end else begin
                exp_cmd(1'b0, 1'b1, 6'(40 + na % 16), 16'(na + 16'h1000));
                na++;
            end
            tick();
        end
    endtask

    task automatic chk_rsp(input bit port, input logic [DW-1:0] d);
        rsp_t e;
        total++;
        if (rsp_q.size() == 0) begin
            bad++;
            $display("FAIL rvalid_%s cyc=%0d: unexpected response data=%h, required none",
                     port ? "b" : "a", cyc, d);
        end else begin
            e = rsp_q.pop_front();
            if (e.cyc != cyc || e.port != port || e.data !== d) begin
                bad++;
                $display("FAIL rvalid_%s cyc=%0d: got port=%0d data=%h, required cyc=%0d port=%0d data=%h",
                         port ? "b" : "a", cyc, port, d, e.cyc, e.port, e.data);
            end
        end
    endtask

    cmd_t ce;
    prb_t pe;
    logic [15:0] act;
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            total++;
            if (cmd_q.size() == 0) begin
                bad++;
                $display("FAIL cmd cyc=%0d: unexpected command a_gnt=%b b_gnt=%b addr=%0d, required none",
                         cyc, bus.a_gnt, bus.b_gnt, bus.mem_addr);
            end else begin
                ce = cmd_q.pop_front();
                if (ce.cyc != cyc || bus.a_gnt !== !ce.port || bus.b_gnt !== ce.port ||
                    bus.mem_we !== ce.we || bus.mem_addr !== ce.addr || bus.mem_wdata !== ce.wdata) begin
                    bad++;
                    $display("FAIL cmd cyc=%0d: got gnt a/b=%b/%b we=%b addr=%0d wdata=%h, required cyc=%0d gnt a/b=%b/%b we=%b addr=%0d wdata=%h",
                             cyc, bus.a_gnt, bus.b_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                             ce.cyc, !ce.port, ce.port, ce.we, ce.addr, ce.wdata);
                end
            end
        end
        while (cmd_q.size() != 0 && cmd_q[0].cyc < cyc + (bus.mem_en === 1'b1 ? 0 : 1)) begin
            ce = cmd_q.pop_front();
            total++; bad++;
            $display("FAIL cmd_missing cyc=%0d: got no grant, required port=%0d addr=%0d at cyc=%0d",
                     cyc, ce.port, ce.addr, ce.cyc);
        end
        if (bus.a_rvalid !== 1'b0) chk_rsp(1'b0, bus.a_rdata);
        if (bus.b_rvalid !== 1'b0) chk_rsp(1'b1, bus.b_rdata);
        while (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
            total++; bad++;
            $display("FAIL rvalid_missing cyc=%0d: got no rvalid, required port=%0d data=%h",
                     cyc, rsp_q[0].port, rsp_q[0].data);
            void'(rsp_q.pop_front());
        end
        while (prb_q.size() != 0 && prb_q[0].cyc <= cyc) begin
            pe = prb_q.pop_front();
            case (pe.kind)
                K_CTL:   act = {10'd0, bus.a_gnt, bus.b_gnt, bus.mem_en, bus.mem_we, bus.a_rvalid, bus.b_rvalid};
                K_CONF:  act = bus.conflicts;
                K_ARD:   act = bus.a_rdata;
                default: act = bus.b_rdata;
            endcase
            total++;
            if (act !== pe.val) begin
                bad++;
                $display("FAIL probe%0d cyc=%0d: got %h, required %h", pe.kind, cyc, act, pe.val);
            end
        end
        if (done) begin
            total++;
            if (cmd_q.size() + rsp_q.size() + prb_q.size() != 0) begin
                bad++;
                $display("FAIL leftover: got cmd=%0d rsp=%0d probe=%0d pending, required 0",
                         cmd_q.size(), rsp_q.size(), prb_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 1'b0, 1'b0, 6'd0, 16'd0);
        tick();
        // reset held with both ports requesting: nothing may issue
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 16'd0, 1'b1, 1'b0, 6'd0, 16'd0);
            probe(K_CTL, 16'd0); probe(K_CONF, 16'd0); probe(K_ARD, 16'd0); probe(K_BRD, 16'd0);
            tick();
        end

        // A-only read of addr 1 (=10)
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 16'd0, 1'b0, 1'b0, 6'd0, 16'd0);
        exp_cmd(1'b0, 1'b0, 6'd1, 16'd0); exp_rsp(1'b0, 16'd10);
        tick();
        idle(); tick();
        idle(); probe(K_ARD, 16'd10); probe(K_CTL, 16'd0); tick();

        // write then read addr 3
        drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd3, 16'h00AB, 1'b0, 1'b0, 6'd0, 16'd0);
        exp_cmd(1'b0, 1'b1, 6'd3, 16'h00AB);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 16'd0, 1'b0, 1'b0, 6'd0, 16'd0);
        exp_cmd(1'b0, 1'b0, 6'd3, 16'd0); exp_rsp(1'b0, 16'h00AB);
        tick();
        idle(); probe(K_CONF, 16'd0); tick();

        // starvation: A A A B A A A B, eight conflict cycles
        contend(8);
        idle(); probe(K_CONF, 16'd8); tick();

        // flush on an A read grant: granted, but no response
        drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd5, 16'd0, 1'b0, 1'b0, 6'd0, 16'd0);
        exp_cmd(1'b0, 1'b0, 6'd5, 16'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b0, 6'd6, 16'd0);
        exp_cmd(1'b1, 1'b0, 6'd6, 16'd0); exp_rsp(1'b1, 16'd60); probe(K_ARD, 16'h00AB);
        tick();
        // flush in the response cycle of an A read, with B reading under flush
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd7, 16'd0, 1'b0, 1'b0, 6'd0, 16'd0);
        exp_cmd(1'b0, 1'b0, 6'd7, 16'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b0, 6'd1, 16'd0);
        exp_cmd(1'b1, 1'b0, 6'd1, 16'd0); exp_rsp(1'b1, 16'd10); probe(K_ARD, 16'h00AB);
        tick();
        idle(); probe(K_ARD, 16'h00AB); tick();

        // B withdraws after one denied cycle: its wait count must restart
        drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd30, 16'd5, 1'b1, 1'b0, 6'd20, 16'd0);
        exp_cmd(1'b0, 1'b1, 6'd30, 16'd5);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd31, 16'd6, 1'b0, 1'b0, 6'd20, 16'd0);
        exp_cmd(1'b0, 1'b1, 6'd31, 16'd6);
        tick();
        contend(4);

        // reset right after a B read grant: the response is dropped
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b0, 6'd6, 16'd0);
        exp_cmd(1'b1, 1'b0, 6'd6, 16'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 16'd0, 1'b1, 1'b0, 6'd6, 16'd0);
        probe(K_CTL, 16'd0); probe(K_BRD, 16'd0); probe(K_CONF, 16'd0); probe(K_ARD, 16'd0);
        tick();
        idle(); probe(K_CTL, 16'd0); probe(K_BRD, 16'd0); probe(K_CONF, 16'd0); tick();

        // reset clears a partially accumulated b_wait
        contend(2);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd40, 16'd0, 1'b1, 1'b0, 6'd20, 16'd0);
        probe(K_CTL, 16'd0);
        tick();
        contend(4);
        idle(); probe(K_CONF, 16'd4); tick();

        // saturation of the conflict counter
        contend(65540);
        idle(); probe(K_CONF, 16'hFFFF); tick();
        idle(); probe(K_CONF, 16'hFFFF); tick();
        idle(); tick();
        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("FAIL monitor: summary not reached");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 6, data-memory word-address width (64 words).
REQ-002 Parameter DW, default 16, data word width.
REQ-003 Parameter MAX_WAIT, default 3, range 1..15: consecutive denied cycles after which port B overrides port A.
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge only.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 flush  in  1  pipeline branch/flush; cancels the port A read response in flight.
REQ-007 a_req  in  1  port A (pipeline memory stage) request; held high until granted.
REQ-008 a_we  in  1  port A write when 1, read when 0.
REQ-009 a_addr  in  AW  port A word address.
REQ-010 a_wdata  in  DW  port A write data.
REQ-011 a_gnt  out  1  port A granted this cycle (combinational).
REQ-012 a_rvalid  out  1  port A read data valid.
REQ-013 a_rdata  out  DW  port A read data.
REQ-014 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B (debug/dump requester), same widths and meanings as the port A signals.
REQ-015 mem_en  out  1  memory command strobe.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_addr  out  AW  memory address.
REQ-018 mem_wdata  out  DW  memory write data.
REQ-019 mem_rdata  in  DW  memory read data, valid one cycle after a read command.
REQ-020 conflicts  out  16  count of cycles in which a_req and b_req were both high.

Function
REQ-021 At most one of a_gnt and b_gnt SHALL be high in any cycle.
REQ-022 Grant priority in each cycle:
  - B when b_req=1 and b_wait==MAX_WAIT;
  - otherwise A when a_req=1;
  - otherwise B when b_req=1;
  - otherwise neither.
REQ-023 mem_en SHALL equal a_gnt|b_gnt; mem_we/mem_addr/mem_wdata SHALL be taken from the granted port in the same cycle; all three SHALL be 0 when no port is granted.
REQ-024 b_wait (4-bit register) SHALL increment, saturating at MAX_WAIT, on each cycle with b_req=1 and b_gnt=0, and SHALL clear to 0 on b_gnt or when b_req=0.
REQ-025 A granted read SHALL produce x_rvalid=1 exactly one cycle later, with x_rdata=mem_rdata in that cycle; writes SHALL produce no rvalid.
REQ-026 rvalid SHALL be a one-cycle pulse; x_rdata SHALL hold its last value while rvalid=0.
REQ-027 flush=1 in cycle N SHALL:
  - suppress a_rvalid in cycle N+1 for an A read granted in cycle N;
  - suppress a_rvalid in cycle N itself.
REQ-028 flush SHALL NOT block A grants in cycle N and SHALL NOT affect port B in any way.
REQ-029 Back-to-back grants to either port SHALL be sustained at one command per cycle.
REQ-030 conflicts SHALL increment by 1 on each cycle with a_req=1 and b_req=1, and SHALL saturate at 16'hFFFF.
REQ-031 A request deasserted before its grant SHALL be treated as withdrawn, with no side effect.

Reset
REQ-032 rst=1 at a rising edge SHALL clear:
  - b_wait to 0 and conflicts to 0;
  - the in-flight read tags to 0;
  - a_rvalid, b_rvalid, a_rdata and b_rdata to 0.
REQ-033 While rst=1, a_gnt, b_gnt, mem_en and mem_we SHALL be forced to 0, so no memory command issues.
REQ-034 A read granted in the cycle before reset asserts SHALL produce no rvalid.

Verification
REQ-035 A-only read: a_req=1, a_we=0, a_addr=1, mem returns 10 -> a_gnt same cycle, mem_en=1, mem_addr=1; next cycle a_rvalid=1, a_rdata=10.
REQ-036 Starvation: a_req and b_req both high continuously, MAX_WAIT=3 -> A granted in cycles 0-2, B granted in cycle 3, A in cycles 4-6, B in cycle 7; conflicts=8 after 8 cycles.
REQ-037 Flush: A read of addr 5 granted in cycle N with flush=1 in cycle N -> a_rvalid stays 0 in cycle N+1; a B read granted in cycle N+1 returns b_rvalid=1 in cycle N+2.
REQ-038 Write then read: A write addr 3 data 16'h00AB, then A read addr 3 on the next cycle (behind a 1-cycle memory model) -> mem_we=1 then 0; a_rdata=16'h00AB one cycle after the read grant.
REQ-039 Reset mid-operation: B read granted in cycle N, rst=1 in cycle N+1 -> b_rvalid=0, b_rdata=0, conflicts=0 and b_wait=0 in cycle N+1; all grants remain 0 while rst=1.
REQ-040 Saturation: force 65540 conflict cycles -> conflicts holds at 16'hFFFF.
